// File: rtl/vga_timing_pkg.sv
// Shared raster definitions: phase encoding, 640x480@60 defaults and sizing helpers
// used by the timing generator, address generator and other raster blocks.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam bit DEF_HS_POL   = 1'b0;
    localparam bit DEF_VS_POL   = 1'b0;

    localparam int H_CNT_W = 11;
    localparam int V_CNT_W = 10;

    function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    // Bits needed to hold positions 0..total-1.
    function automatic int cnt_width(input int total);
        int w;
        w = 1;
        while ((1 << w) < total) w++;
        return w;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle: the generator (master) drives syncs, DE, markers and counters;
// the consumer (slave) supplies the advance enable.
interface vga_timing_if;
    import vga_timing_pkg::*;

    logic               EN;
    logic               HSYNC;
    logic               VSYNC;
    logic               DE;
    logic               LINE_START;
    logic               FRAME_START;
    logic [H_CNT_W-1:0] H_CNT;
    logic [V_CNT_W-1:0] V_CNT;

    modport master (
        input  EN,
        output HSYNC, VSYNC, DE, LINE_START, FRAME_START, H_CNT, V_CNT
    );

    modport slave (
        output EN,
        input  HSYNC, VSYNC, DE, LINE_START, FRAME_START, H_CNT, V_CNT
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus ACTIVE/FP/SYNC/BP phase FSM.
// Exposes next-state values so the top can register outputs aligned with the count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int SEG_ACTIVE = DEF_H_ACTIVE,
    parameter int SEG_FP     = DEF_H_FP,
    parameter int SEG_SYNC   = DEF_H_SYNC,
    parameter int SEG_BP     = DEF_H_BP,
    parameter int CNT_W      = H_CNT_W
) (
    input  logic             PCLK,
    input  logic             RESET,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output phase_t           phase,
    output logic [CNT_W-1:0] next_count,
    output phase_t           next_phase,
    output logic             wrap
);

    localparam int TOTAL = axis_total(SEG_ACTIVE, SEG_FP, SEG_SYNC, SEG_BP);

    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] END_ACTIVE = CNT_W'(SEG_ACTIVE - 1);
    localparam logic [CNT_W-1:0] END_FP     = CNT_W'(SEG_ACTIVE + SEG_FP - 1);
    localparam logic [CNT_W-1:0] END_SYNC   = CNT_W'(SEG_ACTIVE + SEG_FP + SEG_SYNC - 1);

    always_comb begin
        next_count = count;
        next_phase = phase;
        wrap       = tick && (count == LAST);
        if (tick) begin
            next_count = wrap ? '0 : count + CNT_W'(1);
            case (phase)
                PH_ACTIVE: if (count == END_ACTIVE) next_phase = PH_FP;
                PH_FP:     if (count == END_FP)     next_phase = PH_SYNC;
                PH_SYNC:   if (count == END_SYNC)   next_phase = PH_BP;
                PH_BP:     if (count == LAST)       next_phase = PH_ACTIVE;
                default:                            next_phase = PH_BP;
            endcase
        end
    end

    // Reset parks the axis on its final position so the first tick lands on 0.
    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            count <= LAST;
            phase <= PH_BP;
        end else begin
            count <= next_count;
            phase <= next_phase;
        end
    end

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing: H/V axis counters and registered sync/DE/marker decode, all outputs
// aligned to the H_CNT/V_CNT presented in the same cycle.
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = DEF_HS_POL,
    parameter bit VS_POL   = DEF_VS_POL
) (
    input  logic         PCLK,
    input  logic         RESET,
    vga_timing_if.master vga
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_chk_seg
        $fatal(1, "vga_timing_generator: every segment length must be at least 1");
    end
    if (cnt_width(H_TOTAL) > H_CNT_W) begin : g_chk_h
        $fatal(1, "vga_timing_generator: H_TOTAL exceeds 2048");
    end
    if (cnt_width(V_TOTAL) > V_CNT_W) begin : g_chk_v
        $fatal(1, "vga_timing_generator: V_TOTAL exceeds 1024");
    end

    logic [H_CNT_W-1:0] h_cnt, h_next;
    logic [V_CNT_W-1:0] v_cnt, v_next;
    phase_t             h_ph, h_next_ph, v_ph, v_next_ph;
    logic               h_wrap, v_wrap;

    vga_axis_counter #(
        .SEG_ACTIVE (H_ACTIVE),
        .SEG_FP     (H_FP),
        .SEG_SYNC   (H_SYNC),
        .SEG_BP     (H_BP),
        .CNT_W      (H_CNT_W)
    ) u_h_axis (
        .PCLK       (PCLK),
        .RESET      (RESET),
        .tick       (vga.EN),
        .count      (h_cnt),
        .phase      (h_ph),
        .next_count (h_next),
        .next_phase (h_next_ph),
        .wrap       (h_wrap)
    );

    vga_axis_counter #(
        .SEG_ACTIVE (V_ACTIVE),
        .SEG_FP     (V_FP),
        .SEG_SYNC   (V_SYNC),
        .SEG_BP     (V_BP),
        .CNT_W      (V_CNT_W)
    ) u_v_axis (
        .PCLK       (PCLK),
        .RESET      (RESET),
        .tick       (h_wrap),
        .count      (v_cnt),
        .phase      (v_ph),
        .next_count (v_next),
        .next_phase (v_next_ph),
        .wrap       (v_wrap)
    );

    // Current-state axis values are carried by the registered outputs themselves.
    logic unused_axis;
    assign unused_axis = ^{h_ph, v_ph, h_next, v_next};

    // Decode from next-state phases so each flop matches the counter it lands with.
    // With EN low the next phases equal the current ones, so levels hold and wraps stay 0.
    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            vga.DE          <= 1'b0;
            vga.HSYNC       <= ~HS_POL;
            vga.VSYNC       <= ~VS_POL;
            vga.LINE_START  <= 1'b0;
            vga.FRAME_START <= 1'b0;
        end else begin
            vga.DE          <= (h_next_ph == PH_ACTIVE) && (v_next_ph == PH_ACTIVE);
            vga.HSYNC       <= (h_next_ph == PH_SYNC) ? HS_POL : ~HS_POL;
            vga.VSYNC       <= (v_next_ph == PH_SYNC) ? VS_POL : ~VS_POL;
            vga.LINE_START  <= h_wrap;
            vga.FRAME_START <= v_wrap;
        end
    end

    assign vga.H_CNT = h_cnt;
    assign vga.V_CNT = v_cnt;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: a default 640x480 instance and a reduced, inverted-polarity
// instance, both compared every cycle against an arithmetic raster model.
module tb_vga_timing_generator;
    import vga_timing_pkg::*;

    // Reduced raster for the frame-level scenarios.
    localparam int SHA = 16, SHF = 3, SHS = 5, SHB = 4;
    localparam int SVA = 10, SVF = 2, SVS = 2, SVB = 3;
    localparam int HTS = SHA + SHF + SHS + SHB;
    localparam int VTS = SVA + SVF + SVS + SVB;
    localparam int HTD = 800, VTD = 525;

    logic PCLK = 1'b0;
    logic rst_d, rst_s;
    always #5 PCLK = ~PCLK;

    vga_timing_if if_d();
    vga_timing_if if_s();

    vga_timing_generator dut_d (
        .PCLK  (PCLK),
        .RESET (rst_d),
        .vga   (if_d.master)
    );

    vga_timing_generator #(
        .H_ACTIVE (SHA), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
        .V_ACTIVE (SVA), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB),
        .HS_POL   (1'b1), .VS_POL (1'b1)
    ) dut_s (
        .PCLK  (PCLK),
        .RESET (rst_s),
        .vga   (if_s.master)
    );

    typedef struct packed {
        int h;
        int v;
        bit ls;
        bit fs;
    } mdl_t;

    mdl_t m_d, m_s;
    int   n_checks = 0;
    int   n_errors = 0;

    wire [25:0] obs_d = {if_d.HSYNC, if_d.VSYNC, if_d.DE, if_d.LINE_START, if_d.FRAME_START,
                         if_d.H_CNT, if_d.V_CNT};
    wire [25:0] obs_s = {if_s.HSYNC, if_s.VSYNC, if_s.DE, if_s.LINE_START, if_s.FRAME_START,
                         if_s.H_CNT, if_s.V_CNT};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset(input int ht, input int vt);
        mdl_t r;
        r.h = ht - 1; r.v = vt - 1; r.ls = 1'b0; r.fs = 1'b0;
        return r;
    endfunction

    // One enabled pixel: advance position in raster order; markers only on enabled cycles.
    function automatic mdl_t mdl_adv(input mdl_t m, input int ht, input int vt, input bit en);
        mdl_t r;
        r = m; r.ls = 1'b0; r.fs = 1'b0;
        if (en) begin
            r.h  = (m.h + 1) % ht;
            if (r.h == 0) r.v = (m.v + 1) % vt;
            r.ls = (r.h == 0);
            r.fs = (r.h == 0) && (r.v == 0);
        end
        return r;
    endfunction

    function automatic logic [25:0] mdl_out(input mdl_t m, input int ha, input int hf, input int hs,
                                            input int va, input int vf, input int vs,
                                            input bit hp, input bit vp);
        bit de, hsy, vsy;
        de  = (m.h < ha) && (m.v < va);
        hsy = (m.h >= ha + hf && m.h < ha + hf + hs) ? hp : ~hp;
        vsy = (m.v >= va + vf && m.v < va + vf + vs) ? vp : ~vp;
        return {hsy, vsy, de, m.ls, m.fs, 11'(m.h), 10'(m.v)};
    endfunction

    function automatic logic [25:0] exp_d();
        return mdl_out(m_d, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0);
    endfunction

    function automatic logic [25:0] exp_s();
        return mdl_out(m_s, SHA, SHF, SHS, SVA, SVF, SVS, 1'b1, 1'b1);
    endfunction

    task automatic step(input bit ed, input bit es);
        if_d.EN = ed;
        if_s.EN = es;
        @(posedge PCLK);
        #1;
        if (!rst_d) m_d = mdl_adv(m_d, HTD, VTD, ed);
        if (!rst_s) m_s = mdl_adv(m_s, HTS, VTS, es);
        chk("vec_d", 32'(obs_d), 32'(exp_d()));
        chk("vec_s", 32'(obs_s), 32'(exp_s()));
    endtask

    int  de_run, hs_low, hs_min, hs_max, last_ls, n_ls;
    int  last_fs, n_fs, de_cnt, vs_cnt, en_cnt;
    bit  de_fell, seen, ed, es;

    initial begin
        rst_d = 1'b1; rst_s = 1'b1;
        if_d.EN = 1'b0; if_s.EN = 1'b0;
        m_d = mdl_reset(HTD, VTD);
        m_s = mdl_reset(HTS, VTS);

        // Reset held with EN low.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        chk("rst_hcnt", 32'(if_d.H_CNT), 799);
        chk("rst_vcnt", 32'(if_d.V_CNT), 524);
        chk("rst_hsync", 32'(if_d.HSYNC), 1);
        chk("rst_vsync_inv", 32'(if_s.VSYNC), 0);

        rst_d = 1'b0; rst_s = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

        // Free run: line checks on the default raster, frame checks on the reduced one.
        de_run = 0; hs_low = 0; hs_min = 9999; hs_max = -1; last_ls = 0; n_ls = 0; de_fell = 0;
        last_fs = 0; n_fs = 0; de_cnt = 0; vs_cnt = 0;
        for (int k = 0; k < 1700; k++) begin
            step(1'b1, 1'b1);
            if (k == 0) begin
                chk("first_h", 32'(if_d.H_CNT), 0);
                chk("first_v", 32'(if_d.V_CNT), 0);
                chk("first_de", 32'(if_d.DE), 1);
                chk("first_fs", 32'(if_d.FRAME_START), 1);
                chk("first_ls", 32'(if_d.LINE_START), 1);
            end
            if (!de_fell && !if_d.DE) begin
                de_fell = 1'b1;
                chk("de_run", 32'(de_run), 640);
                chk("de_fall_h", 32'(if_d.H_CNT), 640);
            end else if (!de_fell) begin
                de_run++;
            end
            if (k < 800 && !if_d.HSYNC) begin
                hs_low++;
                if (int'(if_d.H_CNT) < hs_min) hs_min = int'(if_d.H_CNT);
                if (int'(if_d.H_CNT) > hs_max) hs_max = int'(if_d.H_CNT);
            end
            if (if_d.LINE_START) begin
                if (k > 0) chk("ls_period", 32'(k - last_ls), 800);
                last_ls = k;
                n_ls++;
            end
            if (if_s.FRAME_START) begin
                if (k > 0) begin
                    chk("fs_period", 32'(k - last_fs), HTS * VTS);
                    chk("de_per_frame", 32'(de_cnt), SHA * SVA);
                    chk("vs_per_frame", 32'(vs_cnt), SVS * HTS);
                end
                last_fs = k; n_fs++; de_cnt = 0; vs_cnt = 0;
            end
            if (if_s.DE) de_cnt++;
            if (if_s.VSYNC) vs_cnt++;
        end
        chk("hs_low_cycles", 32'(hs_low), 96);
        chk("hs_first", 32'(hs_min), 656);
        chk("hs_last", 32'(hs_max), 751);
        chk("ls_count", 32'(n_ls), 3);
        chk("fs_count", 32'(n_fs), 4);

        // Random EN: frame period counted in enabled cycles only.
        seen = 1'b0; en_cnt = 0;
        for (int i = 0; i < 2500; i++) begin
            es = ($urandom_range(0, 3) != 0);
            ed = 1'($urandom_range(0, 1));
            step(ed, es);
            if (es) en_cnt++;
            if (if_s.FRAME_START) begin
                if (seen) chk("fs_en_period", 32'(en_cnt), HTS * VTS);
                seen = 1'b1;
                en_cnt = 0;
            end
        end
        chk("fs_seen", 32'(seen), 1);

        // Mid-frame asynchronous reset on the reduced raster.
        for (int i = 0; i < 1000 && !(m_s.h == 10 && m_s.v == 5); i++) step(1'b1, 1'b1);
        chk("reach_mid", 32'(m_s.h == 10 && m_s.v == 5), 1);
        #2 rst_s = 1'b1;
        #1;
        m_s = mdl_reset(HTS, VTS);
        chk("async_rst", 32'(obs_s), 32'(exp_s()));
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        rst_s = 1'b0;
        step(1'b1, 1'b1);
        chk("restart_h", 32'(if_s.H_CNT), 0);
        chk("restart_fs", 32'(if_s.FRAME_START), 1);
        chk("restart_de", 32'(if_s.DE), 1);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
